// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants, writer state type and byte mux
package fifo_pkg;

    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 16;

    // Widest word the byte mux accepts; callers zero-extend narrower words.
    localparam int MAX_WORD_W = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } wr_state_t;

    // Pick byte idx of word; big-endian order mirrors the index across nbytes.
    function automatic logic [FIFO_DW-1:0] byte_sel(
        input logic [MAX_WORD_W-1:0] word,
        input int unsigned           idx,
        input int unsigned           nbytes,
        input logic                  big_endian
    );
        int unsigned             sel;
        logic [MAX_WORD_W-1:0]   shifted;
        sel     = big_endian ? (nbytes - 1 - idx) : idx;
        shifted = word >> (sel * FIFO_DW);
        return shifted[FIFO_DW-1:0];
    endfunction

endpackage

// File: rtl/fifo_word_writer_if.sv
// rtl/fifo_word_writer_if.sv - word stream into the FIFO word writer
interface fifo_word_writer_if #(
    parameter int DATA_W = 32
) ();

    localparam int NB_W = $clog2(DATA_W / 8) + 1;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [NB_W-1:0]   s_nbytes;

    modport master (
        output s_valid,
        output s_data,
        output s_nbytes,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_nbytes,
        output s_ready
    );

endinterface

// File: rtl/fifo_word_writer.sv
// rtl/fifo_word_writer.sv - splits stream words into bytes for the 8-bit FIFO
module fifo_word_writer
    import fifo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 0,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    fifo_word_writer_if.slave   s,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [FIFO_DW-1:0]  fifo_din,
    output logic                busy,
    output logic                len_err,
    output logic [CNT_W-1:0]    bytes_written
);

    localparam int BYTES = DATA_W / 8;
    localparam int NB_W  = $clog2(BYTES) + 1;

    wr_state_t         state;
    logic [DATA_W-1:0] hold;
    logic [NB_W-1:0]   idx;
    logic [NB_W-1:0]   len;

    logic last_byte;
    logic accept;
    logic len_ok;

    // Write strobe, word boundary and handshake; ready on the last byte
    // lets the next word follow without a bubble.
    always_comb begin
        fifo_wr   = (state == SEND) && !fifo_full;
        last_byte = fifo_wr && (idx == len - NB_W'(1));
        s.s_ready = (state == IDLE) || last_byte;
        accept    = s.s_valid && s.s_ready;
        len_ok    = (s.s_nbytes != '0) && (s.s_nbytes <= NB_W'(BYTES));
        busy      = (state == SEND);
    end

    // Byte mux on the held word; idle drives zero onto the FIFO data bus.
    always_comb begin
        fifo_din = '0;
        if (state == SEND) begin
            fifo_din = byte_sel(MAX_WORD_W'(hold), 32'(idx), 32'(BYTES), BIG_ENDIAN != 0);
        end
    end

    // Word capture, byte walk and running byte count; a stall simply
    // leaves idx and hold untouched so nothing is lost or repeated.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold          <= '0;
            idx           <= '0;
            len           <= '0;
            len_err       <= 1'b0;
            bytes_written <= '0;
        end else begin
            len_err <= 1'b0;
            if (fifo_wr) begin
                idx           <= idx + NB_W'(1);
                bytes_written <= bytes_written + CNT_W'(1);
            end
            if (accept) begin
                hold    <= s.s_data;
                idx     <= '0;
                len     <= len_ok ? s.s_nbytes : NB_W'(BYTES);
                len_err <= !len_ok;
                state   <= SEND;
            end else if (last_byte) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_writer.sv
// tb/tb_fifo_word_writer.sv - directed vector bench for fifo_word_writer
module tb_fifo_word_writer;

    logic clk = 1'b0;
    logic rst;
    logic fifo_full;

    always #5 clk = ~clk;

    fifo_word_writer_if #(.DATA_W(32)) if_le ();
    fifo_word_writer_if #(.DATA_W(32)) if_be ();

    assign if_be.s_valid  = if_le.s_valid;
    assign if_be.s_data   = if_le.s_data;
    assign if_be.s_nbytes = if_le.s_nbytes;

    logic        wr_le, wr_be, busy_le, busy_be, lerr_le, lerr_be;
    logic [7:0]  din_le, din_be;
    logic [15:0] bw_le;
    logic [3:0]  bw_be;

    fifo_word_writer #(.DATA_W(32), .BIG_ENDIAN(0), .CNT_W(16)) u_le (
        .clk           (clk),
        .rst           (rst),
        .s             (if_le.slave),
        .fifo_full     (fifo_full),
        .fifo_wr       (wr_le),
        .fifo_din      (din_le),
        .busy          (busy_le),
        .len_err       (lerr_le),
        .bytes_written (bw_le)
    );

    fifo_word_writer #(.DATA_W(32), .BIG_ENDIAN(1), .CNT_W(4)) u_be (
        .clk           (clk),
        .rst           (rst),
        .s             (if_be.slave),
        .fifo_full     (fifo_full),
        .fifo_wr       (wr_be),
        .fifo_din      (din_be),
        .busy          (busy_be),
        .len_err       (lerr_be),
        .bytes_written (bw_be)
    );

    typedef struct {
        logic        v;
        logic [31:0] data;
        logic [2:0]  nb;
        logic        rdy;
        logic        wr;
        logic [7:0]  le;
        logic [7:0]  be;
        logic        busy;
        logic        lerr;
        logic [15:0] bw;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] fifo_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] data, input logic [2:0] nb,
                                input logic rdy, input logic wr, input logic [7:0] le,
                                input logic [7:0] be, input logic busy, input logic lerr,
                                input logic [15:0] bw);
        vec_t r;
        r.v = v; r.data = data; r.nb = nb; r.rdy = rdy; r.wr = wr;
        r.le = le; r.be = be; r.busy = busy; r.lerr = lerr; r.bw = bw;
        return r;
    endfunction

    // One cycle against the bench FIFO model: full reflects occupancy at
    // cycle start, writes and pops land on the rising edge.
    task automatic bp_cycle(input bit pop, output logic wr, output logic [7:0] din,
                            output logic rdy, output logic bsy);
        fifo_full = (fifo_q.size() >= 16);
        @(negedge clk);
        wr  = wr_le;
        din = din_le;
        rdy = if_le.s_ready;
        bsy = busy_le;
        @(posedge clk);
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (wr) fifo_q.push_back(din);
        #1;
    endtask

    logic       w, r, b;
    logic [7:0] d;

    initial begin
        rst             = 1'b1;
        fifo_full       = 1'b0;
        if_le.s_valid   = 1'b0;
        if_le.s_data    = '0;
        if_le.s_nbytes  = '0;

        // single word
        tbl.push_back(mk(0, 32'h0,        0, 1, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 32'hA1B2C3D4, 4, 1, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'hD4, 8'hA1, 1, 0, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'hC3, 8'hB2, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'hB2, 8'hC3, 1, 0, 2));
        tbl.push_back(mk(0, 32'h0,        0, 1, 1, 8'hA1, 8'hD4, 1, 0, 3));
        tbl.push_back(mk(0, 32'h0,        0, 1, 0, 8'h00, 8'h00, 0, 0, 4));
        // partial word, 2 bytes
        tbl.push_back(mk(1, 32'h11223344, 2, 1, 0, 8'h00, 8'h00, 0, 0, 4));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'h44, 8'h11, 1, 0, 4));
        tbl.push_back(mk(0, 32'h0,        0, 1, 1, 8'h33, 8'h22, 1, 0, 5));
        tbl.push_back(mk(0, 32'h0,        0, 1, 0, 8'h00, 8'h00, 0, 0, 6));
        // illegal length 0
        tbl.push_back(mk(1, 32'h55667788, 0, 1, 0, 8'h00, 8'h00, 0, 0, 6));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'h88, 8'h55, 1, 1, 6));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'h77, 8'h66, 1, 0, 7));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'h66, 8'h77, 1, 0, 8));
        tbl.push_back(mk(0, 32'h0,        0, 1, 1, 8'h55, 8'h88, 1, 0, 9));
        tbl.push_back(mk(0, 32'h0,        0, 1, 0, 8'h00, 8'h00, 0, 0, 10));
        // illegal length 5 > BYTES
        tbl.push_back(mk(1, 32'hCAFEBABE, 5, 1, 0, 8'h00, 8'h00, 0, 0, 10));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'hBE, 8'hCA, 1, 1, 10));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'hBA, 8'hFE, 1, 0, 11));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'hFE, 8'hBA, 1, 0, 12));
        tbl.push_back(mk(0, 32'h0,        0, 1, 1, 8'hCA, 8'hBE, 1, 0, 13));
        tbl.push_back(mk(0, 32'h0,        0, 1, 0, 8'h00, 8'h00, 0, 0, 14));
        // back-to-back, s_valid held high
        tbl.push_back(mk(1, 32'h01020304, 4, 1, 0, 8'h00, 8'h00, 0, 0, 14));
        tbl.push_back(mk(1, 32'h05060708, 4, 0, 1, 8'h04, 8'h01, 1, 0, 14));
        tbl.push_back(mk(1, 32'h05060708, 4, 0, 1, 8'h03, 8'h02, 1, 0, 15));
        tbl.push_back(mk(1, 32'h05060708, 4, 0, 1, 8'h02, 8'h03, 1, 0, 16));
        tbl.push_back(mk(1, 32'h05060708, 4, 1, 1, 8'h01, 8'h04, 1, 0, 17));
        tbl.push_back(mk(1, 32'h090A0B0C, 4, 0, 1, 8'h08, 8'h05, 1, 0, 18));
        tbl.push_back(mk(1, 32'h090A0B0C, 4, 0, 1, 8'h07, 8'h06, 1, 0, 19));
        tbl.push_back(mk(1, 32'h090A0B0C, 4, 0, 1, 8'h06, 8'h07, 1, 0, 20));
        tbl.push_back(mk(1, 32'h090A0B0C, 4, 1, 1, 8'h05, 8'h08, 1, 0, 21));
        tbl.push_back(mk(1, 32'hDDCCBBAA, 4, 0, 1, 8'h0C, 8'h09, 1, 0, 22));
        tbl.push_back(mk(1, 32'hDDCCBBAA, 4, 0, 1, 8'h0B, 8'h0A, 1, 0, 23));
        tbl.push_back(mk(1, 32'hDDCCBBAA, 4, 0, 1, 8'h0A, 8'h0B, 1, 0, 24));
        tbl.push_back(mk(1, 32'hDDCCBBAA, 4, 1, 1, 8'h09, 8'h0C, 1, 0, 25));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'hAA, 8'hDD, 1, 0, 26));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 8'hBB, 8'hCC, 1, 0, 27));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            if_le.s_valid  = tbl[i].v;
            if_le.s_data   = tbl[i].data;
            if_le.s_nbytes = tbl[i].nb;
            @(negedge clk);
            chk($sformatf("row%0d s_ready", i),   32'(if_le.s_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d fifo_wr", i),   32'(wr_le),         32'(tbl[i].wr));
            chk($sformatf("row%0d din_le", i),    32'(din_le),        32'(tbl[i].le));
            chk($sformatf("row%0d din_be", i),    32'(din_be),        32'(tbl[i].be));
            chk($sformatf("row%0d busy", i),      32'(busy_le),       32'(tbl[i].busy));
            chk($sformatf("row%0d len_err", i),   32'(lerr_le),       32'(tbl[i].lerr));
            chk($sformatf("row%0d bw_le", i),     32'(bw_le),         32'(tbl[i].bw));
            chk($sformatf("row%0d bw_be_wrap", i), 32'(bw_be),        32'(tbl[i].bw[3:0]));
            chk($sformatf("row%0d rdy_be", i),    32'(if_be.s_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
        end

        // reset in the middle of the fourth word
        rst           = 1'b1;
        if_le.s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst fifo_wr", 32'(wr_le),         32'd0);
        chk("rst busy",    32'(busy_le),       32'd0);
        chk("rst bw_le",   32'(bw_le),         32'd0);
        chk("rst bw_be",   32'(bw_be),         32'd0);
        chk("rst s_ready", 32'(if_le.s_ready), 32'd1);
        chk("rst din",     32'(din_le),        32'd0);
        chk("rst len_err", 32'(lerr_le),       32'd0);
        @(posedge clk);
        #1;

        // backpressure against a FIFO pre-filled to 14 entries
        for (int k = 0; k < 14; k++) fifo_q.push_back(8'(8'hE0 + k));
        if_le.s_valid  = 1'b1;
        if_le.s_data   = 32'hA1B2C3D4;
        if_le.s_nbytes = 3'd4;
        bp_cycle(0, w, d, r, b);
        chk("bp accept wr", 32'(w), 32'd0);
        chk("bp accept rdy", 32'(r), 32'd1);
        if_le.s_valid = 1'b0;
        bp_cycle(0, w, d, r, b);
        chk("bp byte0 wr", 32'(w), 32'd1);
        chk("bp byte0 din", 32'(d), 32'hD4);
        bp_cycle(0, w, d, r, b);
        chk("bp byte1 wr", 32'(w), 32'd1);
        chk("bp byte1 din", 32'(d), 32'hC3);
        for (int k = 0; k < 3; k++) begin
            bp_cycle(k == 2, w, d, r, b);
            chk($sformatf("bp stall%0d wr", k),   32'(w), 32'd0);
            chk($sformatf("bp stall%0d din", k),  32'(d), 32'hB2);
            chk($sformatf("bp stall%0d busy", k), 32'(b), 32'd1);
            chk($sformatf("bp stall%0d rdy", k),  32'(r), 32'd0);
        end
        bp_cycle(1, w, d, r, b);
        chk("bp byte2 wr", 32'(w), 32'd1);
        chk("bp byte2 din", 32'(d), 32'hB2);
        bp_cycle(0, w, d, r, b);
        chk("bp byte3 wr", 32'(w), 32'd1);
        chk("bp byte3 din", 32'(d), 32'hA1);
        chk("bp byte3 rdy", 32'(r), 32'd1);
        bp_cycle(0, w, d, r, b);
        chk("bp idle wr", 32'(w), 32'd0);
        chk("bp idle busy", 32'(b), 32'd0);

        chk("fifo level", 32'(fifo_q.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] exp_b;
            logic [31:0] tail;
            tail  = 32'hD4C3B2A1;
            exp_b = (k < 12) ? 8'(8'hE2 + k) : tail[8*(15-k) +: 8];
            if (k < fifo_q.size()) chk($sformatf("fifo[%0d]", k), 32'(fifo_q[k]), 32'(exp_b));
            else                   chk($sformatf("fifo[%0d] missing", k), 32'd0, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
